// File: rtl/adc_scan_spi.sv
// Continuous SPI scanner for an ADC78H90-class 8-input, 12-bit ADC: walks a contiguous
// address range, undoes the one-frame result pipeline and keeps per-channel results or peaks.
module adc_scan_spi #(
    parameter int          NUM_CH    = 6,
    parameter int          FIRST_CH  = 0,
    parameter int          SCLK_DIV  = 2,
    parameter logic [7:0]  PEAK_MASK = 8'b0000_0011
) (
    input  logic                   clock,
    input  logic                   nreset,
    output logic                   SCLK,
    output logic                   nCS,
    output logic                   MOSI,
    input  logic                   MISO,
    output logic [12*NUM_CH-1:0]   ain,
    output logic                   sample_valid,
    output logic [2:0]             sample_ch,
    output logic                   scan_done,
    input  logic                   pk_detect_reset,
    output logic                   pk_detect_ack,
    output logic [1:0]             dbg_state
);

    localparam int                CW        = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [CW-1:0]     CNT_LAST  = CW'(SCLK_DIV - 1);
    localparam logic [2:0]        LAST_IDX  = 3'(NUM_CH - 1);
    localparam logic [2:0]        BASE_ADDR = 3'(FIRST_CH);
    localparam logic [NUM_CH-1:0] PEAK_VEC  = PEAK_MASK[NUM_CH-1:0];

    typedef enum logic [1:0] {
        S_COMMIT = 2'd0,
        S_QUIET  = 2'd1,
        S_LOW    = 2'd2,
        S_HIGH   = 2'd3
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [3:0]             bit_cnt_q;
    logic [15:0]            word_q;
    logic [11:0]            rx_q;
    logic [2:0]             idx_q;
    logic [2:0]             cur_idx_q;
    logic [2:0]             prev_idx_q;
    logic                   primed_q;
    logic [NUM_CH-1:0]      restart_q;
    logic                   ack_q;
    logic [12*NUM_CH-1:0]   ain_q;
    logic                   sclk_q;
    logic                   ncs_q;
    logic                   mosi_q;
    logic                   valid_q;
    logic [2:0]             ch_q;
    logic                   done_q;

    logic [15:0]            word_d;
    logic [2:0]             idx_d;
    logic                   accept_d;
    logic [NUM_CH-1:0]      sel_d;
    logic [11:0]            old_d;
    logic                   hold_d;
    logic [11:0]            new_d;
    logic [NUM_CH-1:0]      restart_d;

    always_comb begin
        word_d   = {2'b00, BASE_ADDR + idx_q, 11'b0};
        idx_d    = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
        accept_d = pk_detect_reset & ~ack_q;
        sel_d    = '0;
        old_d    = '0;
        hold_d   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (prev_idx_q == 3'(k)) begin
                sel_d[k] = primed_q;
                old_d    = ain_q[12*k +: 12];
                hold_d   = PEAK_VEC[k] & ~restart_q[k];
            end
        end
        // A restart accepted in this same COMMIT forces a plain load of the new sample.
        hold_d    = hold_d & ~accept_d & (old_d >= rx_q);
        new_d     = hold_d ? old_d : rx_q;
        restart_d = (restart_q | (accept_d ? PEAK_VEC : '0)) & ~sel_d;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q    <= S_QUIET;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            word_q     <= '0;
            rx_q       <= '0;
            idx_q      <= '0;
            cur_idx_q  <= '0;
            prev_idx_q <= '0;
            primed_q   <= 1'b0;
            restart_q  <= '1;
            ack_q      <= 1'b0;
            ain_q      <= '0;
            sclk_q     <= 1'b0;
            ncs_q      <= 1'b1;
            mosi_q     <= 1'b0;
            valid_q    <= 1'b0;
            ch_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_COMMIT: begin
                    primed_q  <= 1'b1;
                    restart_q <= restart_d;
                    if (accept_d) begin
                        ack_q <= 1'b1;
                    end else if (!pk_detect_reset) begin
                        ack_q <= 1'b0;
                    end
                    // The first frame after reset carries the ADC power-up address; drop it.
                    if (primed_q) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (sel_d[k]) ain_q[12*k +: 12] <= new_d;
                        end
                        valid_q <= 1'b1;
                        ch_q    <= prev_idx_q;
                        done_q  <= (prev_idx_q == LAST_IDX);
                    end
                    state_q <= S_QUIET;
                end
                S_QUIET: begin
                    word_q     <= word_d;
                    bit_cnt_q  <= 4'd15;
                    prev_idx_q <= cur_idx_q;
                    cur_idx_q  <= idx_q;
                    idx_q      <= idx_d;
                    cnt_q      <= '0;
                    ncs_q      <= 1'b0;
                    sclk_q     <= 1'b0;
                    mosi_q     <= word_d[15];
                    state_q    <= S_LOW;
                end
                S_LOW: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        sclk_q  <= 1'b1;
                        state_q <= S_HIGH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q  <= '0;
                        rx_q   <= {rx_q[10:0], MISO};
                        sclk_q <= 1'b0;
                        if (bit_cnt_q == 4'd0) begin
                            ncs_q   <= 1'b1;
                            mosi_q  <= 1'b0;
                            state_q <= S_COMMIT;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 4'd1;
                            mosi_q    <= word_q[bit_cnt_q - 4'd1];
                            state_q   <= S_LOW;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign SCLK          = sclk_q;
    assign nCS           = ncs_q;
    assign MOSI          = mosi_q;
    assign ain           = ain_q;
    assign sample_valid  = valid_q;
    assign sample_ch     = ch_q;
    assign scan_done     = done_q;
    assign pk_detect_ack = ack_q;
    assign dbg_state     = state_q;

endmodule

// File: doc/adc_scan_spi.md
# adc_scan_spi

Parametrised SPI scanner for ADC78H90-class 8-input, 12-bit serial ADCs, the successor to the fixed six-input telemetry ADC driver. It continuously cycles through a programmable, contiguous range of ADC inputs, handles the one-frame result pipeline, and publishes one 12-bit result per channel on a flat bus. Any subset of channels can be set to peak-hold mode under a reset/acknowledge handshake. It sits beside the Tx FIFO control logic and feeds forward/reverse power and supply-voltage telemetry.

## Interface
- NUM_CH, 6: channels scanned, 1..8.
- FIRST_CH, 0: ADC input address of channel 0. FIRST_CH+NUM_CH-1 must be ≤ 7.
- SCLK_DIV, 2: clock cycles per SCLK half-period, ≥1. 30.72 MHz / (2·2) gives 7.68 MHz SCLK.
- PEAK_MASK, 8'b0000_0011: bit k=1 puts channel k in peak-hold mode.
- clock  in  1  system clock.
- nreset  in  1  asynchronous, active-low reset.
- SCLK  out  1  ADC serial clock; idles low.
- nCS  out  1  ADC chip select, active low.
- MOSI  out  1  ADC DIN.
- MISO  in  1  ADC DOUT.
- ain  out  12·NUM_CH  channel k occupies bits [12k+11:12k].
- sample_valid  out  1  one-cycle pulse when a result is committed.
- sample_ch  out  3  channel index of the committed result; valid with sample_valid.
- scan_done  out  1  one-cycle pulse, coincident with the commit of channel NUM_CH-1.
- pk_detect_reset  in  1  peak-interval restart request (4-phase).
- pk_detect_ack  out  1  acknowledge of pk_detect_reset.

## Operation
- States:
  - COMMIT: 1 cycle, nCS=1.
  - QUIET: 1 cycle, nCS=1; loads the 16-bit control word and sets bit_cnt=15.
  - LOW: SCLK_DIV cycles, nCS=0, SCLK=0. MOSI=word[bit_cnt] is driven on entry.
  - HIGH: SCLK_DIV cycles, SCLK=1. MISO is sampled into rx[bit_cnt] on the last cycle.
- HIGH transitions to LOW with bit_cnt−1, or to COMMIT after bit 0.
- Reset enters QUIET.
- Control word: bits [13:11] = FIRST_CH + idx, all other bits 0.
  - idx increments in QUIET and wraps NUM_CH−1 → 0.
  - The first frame after reset uses idx=0.
- Pipeline: the data received in frame n belongs to the address sent in frame n−1.
  - prev_idx is the index sent in the previous frame.
  - result = rx[11:0]; rx[15:12] are ignored.
- A primed flag is cleared by reset. The first COMMIT after reset sets primed and commits nothing, because its data is from the ADC power-up address.
- COMMIT with primed=1:
  - Non-peak channel: ain[prev_idx] ← result.
  - Peak channel, restart flag set: ain[prev_idx] ← result and the restart flag clears.
  - Peak channel, restart flag clear: ain[prev_idx] ← max(ain[prev_idx], result), unsigned 12-bit compare.
  - sample_valid=1 and sample_ch=prev_idx.
  - scan_done=1 when prev_idx=NUM_CH−1.
- Peak handshake, evaluated only in COMMIT, including the unprimed COMMIT:
  - pk_detect_reset=1 and ack=0: set the restart flag of every peak channel and set ack=1.
  - pk_detect_reset=0 and ack=1: ack ← 0.
  - Otherwise ack holds. Holding the request high does not restart again.
- Simultaneous restart and commit to a peak channel: the committed result loads unconditionally and that channel's restart flag ends cleared.
- Until a peak channel's first post-restart sample arrives, ain shows the old peak.

## Timing
- Frame = 32·SCLK_DIV + 2 cycles (66 cycles at SCLK_DIV=2). nCS is high for exactly 2 cycles per frame.
- The ADC latches MOSI on the SCLK rising edge. MOSI is stable SCLK_DIV cycles before that edge.
- Scan period = NUM_CH frames.
- Latency from the last SCLK falling edge of a frame to the ain update and sample_valid is 1 cycle (the COMMIT register edge).
- Ack rise or fall occurs only at COMMIT, so worst-case response is one frame.
- pk_detect_reset is a synchronous, same-clock-domain input; no synchroniser is included.
- Reset values: SCLK=0, nCS=1, MOSI=0, ain=0, sample_valid=0, sample_ch=0, scan_done=0, pk_detect_ack=0. All restart flags = 1, primed = 0.
- nreset asserted mid-frame: all outputs take their reset values immediately. After release, scanning restarts at idx=0 with primed=0.

## Test plan
- Default parameters; ADC model returns 12'h100+address.
  - First COMMIT produces no sample_valid.
  - Then ain[k] = 12'h100+k with the k=0..5 commit order.
  - scan_done every 6 frames; frame length exactly 66 cycles.
  - MOSI bits [13:11] walk 0..5.
- NUM_CH=3, FIRST_CH=4, SCLK_DIV=1:
  - Addresses 4,5,6 repeat.
  - Frame length 34 cycles.
  - ain[1] equals the model value for address 5.
- Peak channel 0 with model values 300, 800, 200:
  - ain[0] reads 300 → 800 → 800.
  - Raise pk_detect_reset. Ack rises at the next COMMIT.
  - Next channel-0 sample 150 gives ain[0]=150.
  - Held request causes no further restart.
  - Drop the request; ack falls at the next COMMIT.
- Restart accepted in the same COMMIT as a channel-0 commit of value 50: ain[0]=50. The later sample 40 keeps ain[0]=50.
- nreset pulsed while bit_cnt=7:
  - nCS=1, SCLK=0, ain=0 and ack=0 asynchronously.
  - Rescan starts at address FIRST_CH.
  - First post-reset COMMIT is discarded.
